block_arbiter: RTL
==================

Name: block_arbiter

Overview:
Round-robin scheduler that shares one 8x8 block datapath between several block sources, e.g. the Y, Cb and Cr row streams feeding the matrix_buffer/DCT chain. Each source requests when it holds a complete block. The arbiter grants whole blocks atomically and muxes the 8 contiguous rows onto one output stream. It generates sob/eob framing, forwards sof, and tags each block with its source index.

Parameters:
N_SRC, 3, number of requesting sources (2..8)
W_IO, 8, width of one sample; a row is 8 samples
GAP, 0, number of idle cycles forced on the output after each block (0..15)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
src_req  input  N_SRC  per-source request: a full block is ready
src_gnt  output  N_SRC  one-hot grant; held high while that source's rows are taken
src_data  input  N_SRC x 8 x W_IO  per-source row data (source i drives src_data[i])
src_sof  input  N_SRC  per-source start-of-frame flag, valid on row 0
out_valid  output  1  output row valid
out_data  output  8 x W_IO  output row
out_sob  output  1  first row of block
out_eob  output  1  last row of block
out_sof  output  1  first row of first block of frame
out_src  output  max(1,$clog2(N_SRC))  index of source owning current output row
busy  output  1  high in XFER or GAP state

Behaviour:
- Reset (async, rst_n low): state IDLE; row and gap counters 0; round-robin pointer = N_SRC-1, so source 0 has first priority. src_gnt, out_valid, out_sob, out_eob, out_sof, busy, out_data and out_src are all 0.
- States:
  - IDLE
  - XFER: row counter 0..7
  - GAP: gap counter 0..GAP-1
- Decision points, where src_req is sampled:
  - any IDLE cycle;
  - XFER row 7 when GAP=0;
  - the last GAP cycle when GAP>0.
- Winner selection: the first asserted src_req searching from pointer+1 upward, with wrap-around. On a win the pointer becomes the winner index.
- Timing: decision at cycle t. src_gnt[winner] is registered high for cycles t+1..t+8. The source must present row r on src_data[winner] in cycle t+1+r, with no stalls. Rows are captured unconditionally.
- Output is registered, one cycle after capture:
  - out_valid is high t+2..t+9;
  - out_sob only on the first row (t+2);
  - out_eob only on the last row (t+9);
  - out_sof = src_sof[winner] sampled at row 0, on the first row only;
  - out_src is constant for all 8 rows.
- out_data and out_src hold their last value when out_valid is 0.
- After row 7 of XFER:
  - GAP=0: at the decision point, a win goes straight to XFER row 0, giving back-to-back blocks and continuous out_valid; otherwise the state goes to IDLE.
  - GAP>0: go to GAP for exactly GAP cycles, then to XFER (win) or IDLE (no win).
- Out-of-window requests: src_req changes outside a decision point are ignored. A request raised during XFER waits. Dropping src_req during an active grant does not abort; all 8 rows are transferred.
- Repeated grants: a source may be granted again at the next decision point only if no other source is requesting, which follows from round-robin order.
- src_gnt has at most one bit high at any time. It deasserts the cycle after row 7 unless the same source wins again.
- Reset mid-block: all outputs are 0 immediately; the truncated block is discarded, with no eob emitted. The first block after reset starts with sob and honours src_sof.

Test Plan:
- Single block: src_req=3'b010 for 1 cycle from IDLE, src_data[1] rows 0x11..0x18 -> src_gnt=3'b010 for 8 cycles; out_valid for 8 cycles starting 2 cycles after the request; rows 0x11..0x18 in order; sob on 0x11, eob on 0x18; out_src=1.
- Contention: src_req=3'b111 held, GAP=0 -> grant order 0,1,2,0; 32 consecutive out_valid cycles; out_src steps 0,1,2,0 every 8 rows; exactly 4 sob and 4 eob.
- Same source back-to-back: only src_req[2] held for 16 cycles -> two blocks, no idle cycle between eob and the next sob, out_src=2 throughout.
- Gap: GAP=3, src_req=3'b011 held -> exactly 3 cycles of out_valid=0 between each eob and the next sob; busy stays high across the gap.
- sof and drop: src_sof[0]=1 on row 0 and src_req[0] dropped at row 3 -> out_sof only on the first row, full 8-row block delivered, next block out_sof=0.
- Reset mid-transfer: rst_n low at row 4 -> all outputs 0 in the same cycle; after release with src_req=3'b100, the first grant goes to source 2 and the block starts with sob, pointer restored to its reset state.

Source files
------------

// File: rtl/block_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : block_arbiter_if
//  Description : Bundle between the block sources and the block arbiter.
//                Source side : src_req, src_gnt, src_data, src_sof
//                Output side : out_valid, out_data, out_sob, out_eob,
//                              out_sof, out_src, busy
//                master = source/sink side, slave = arbiter side.
//  Revision    : 1.0  initial release
// ============================================================================
interface block_arbiter_if #(
    parameter int N_SRC = 3,
    parameter int W_IO  = 8
);
    localparam int c_src_w = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [N_SRC-1:0]                src_req;
    logic [N_SRC-1:0]                src_gnt;
    logic [N_SRC-1:0][7:0][W_IO-1:0] src_data;
    logic [N_SRC-1:0]                src_sof;
    logic                            out_valid;
    logic [7:0][W_IO-1:0]            out_data;
    logic                            out_sob;
    logic                            out_eob;
    logic                            out_sof;
    logic [c_src_w-1:0]              out_src;
    logic                            busy;

    modport master (
        output src_req, src_data, src_sof,
        input  src_gnt, out_valid, out_data, out_sob, out_eob, out_sof,
               out_src, busy
    );

    modport slave (
        input  src_req, src_data, src_sof,
        output src_gnt, out_valid, out_data, out_sob, out_eob, out_sof,
               out_src, busy
    );
endinterface
`default_nettype wire

// File: rtl/block_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : block_arbiter
//  Description : Round-robin scheduler sharing one 8x8 block datapath among
//                N_SRC block sources. Whole blocks (8 rows) are granted
//                atomically and muxed onto a single registered row stream
//                with sob/eob framing, forwarded sof and a source tag.
//  Ports       : clk   - clock
//                rst_n - asynchronous active-low reset
//                bus   - block_arbiter_if.slave (requests, grants, row data,
//                        output row stream, busy)
//  Revision    : 1.0  initial release
// ============================================================================
module block_arbiter #(
    parameter int N_SRC = 3,
    parameter int W_IO  = 8,
    parameter int GAP   = 0
) (
    input wire             clk,
    input wire             rst_n,
    block_arbiter_if.slave bus
);
    localparam int                 c_src_w    = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [2:0]         c_last_row = 3'd7;
    localparam logic [3:0]         c_gap_last = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
    // Pointer starts on the last source so source 0 is searched first.
    localparam logic [c_src_w-1:0] c_ptr_rst  = c_src_w'(N_SRC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [2:0]           r_row, w_row_nxt;
    logic [3:0]           r_gap, w_gap_nxt;
    logic [c_src_w-1:0]   r_ptr, w_ptr_nxt;
    logic [c_src_w-1:0]   r_cur, w_cur_nxt;
    logic [N_SRC-1:0]     r_gnt, w_gnt_nxt;

    logic                 w_decide;
    logic                 w_found;
    logic [c_src_w-1:0]   w_win;
    logic [c_src_w-1:0]   w_idx;

    logic                 r_out_valid;
    logic [7:0][W_IO-1:0] r_out_data;
    logic                 r_out_sob;
    logic                 r_out_eob;
    logic                 r_out_sof;
    logic [c_src_w-1:0]   r_out_src;

    // Round-robin search: first requester strictly after the pointer,
    // wrapping around, so the last winner has lowest priority.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        w_idx   = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            w_idx = c_src_w'((int'(r_ptr) + k) % N_SRC);
            if (!w_found && bus.src_req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // Requests are only looked at in IDLE, on the last row when blocks run
    // back-to-back, or on the last gap cycle.
    always_comb begin
        w_decide = (r_state == S_IDLE)
                || ((r_state == S_XFER) && (r_row == c_last_row) && (GAP == 0))
                || ((r_state == S_GAP)  && (r_gap == c_gap_last));
    end

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_gap_nxt   = r_gap;
        w_ptr_nxt   = r_ptr;
        w_cur_nxt   = r_cur;
        w_gnt_nxt   = '0;

        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_IDLE;
            end
            S_XFER: begin
                w_row_nxt = r_row + 3'd1;
                if (r_row == c_last_row) begin
                    if (GAP == 0) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_GAP;
                        w_gap_nxt   = 4'd0;
                    end
                end
            end
            S_GAP: begin
                w_gap_nxt = r_gap + 4'd1;
                if (r_gap == c_gap_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // A win at a decision point overrides the fall-back above and
        // starts the next block on row 0 without a bubble.
        if (w_decide && w_found) begin
            w_state_nxt = S_XFER;
            w_row_nxt   = 3'd0;
            w_ptr_nxt   = w_win;
            w_cur_nxt   = w_win;
        end

        // Grant is registered alongside the state so it is high exactly
        // for the cycles spent in XFER.
        if (w_state_nxt == S_XFER) begin
            w_gnt_nxt[w_cur_nxt] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_row   <= 3'd0;
            r_gap   <= 4'd0;
            r_ptr   <= c_ptr_rst;
            r_cur   <= '0;
            r_gnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            r_gap   <= w_gap_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cur   <= w_cur_nxt;
            r_gnt   <= w_gnt_nxt;
        end
    end

    // Row capture: every XFER cycle takes the granted source's row; data and
    // tag hold their last value outside a block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sob   <= 1'b0;
            r_out_eob   <= 1'b0;
            r_out_sof   <= 1'b0;
            r_out_src   <= '0;
        end else begin
            r_out_valid <= (r_state == S_XFER);
            r_out_sob   <= (r_state == S_XFER) && (r_row == 3'd0);
            r_out_eob   <= (r_state == S_XFER) && (r_row == c_last_row);
            r_out_sof   <= (r_state == S_XFER) && (r_row == 3'd0) && bus.src_sof[r_cur];
            if (r_state == S_XFER) begin
                r_out_data <= bus.src_data[r_cur];
                r_out_src  <= r_cur;
            end
        end
    end

    assign bus.src_gnt   = r_gnt;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_sob   = r_out_sob;
    assign bus.out_eob   = r_out_eob;
    assign bus.out_sof   = r_out_sof;
    assign bus.out_src   = r_out_src;
    assign bus.busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire
